// File: rtl/wb_conbus_rr.sv
// Shared-bus Wishbone interconnect: NM masters, NS slaves.
// Round-robin arbiter with cycle locking, MSB decode, error watchdog.
module wb_conbus_rr #(
  parameter int NM       = 6,
  parameter int NS       = 8,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int S_ADDR_W = 4,
  parameter logic [NS*S_ADDR_W-1:0] S_ADDR_MAP = 32'h7654_3210,
  parameter int TIMEOUT  = 255
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [NM*DATA_W-1:0]   m_dat_i,
  input  logic [NM*ADDR_W-1:0]   m_adr_i,
  input  logic [NM*3-1:0]        m_cti_i,
  input  logic [NM*DATA_W/8-1:0] m_sel_i,
  input  logic [NM-1:0]          m_we_i,
  input  logic [NM-1:0]          m_cyc_i,
  input  logic [NM-1:0]          m_stb_i,
  output logic [DATA_W-1:0]      m_dat_o,
  output logic [NM-1:0]          m_ack_o,
  output logic [NM-1:0]          m_err_o,
  input  logic [NS*DATA_W-1:0]   s_dat_i,
  input  logic [NS-1:0]          s_ack_i,
  input  logic [NS-1:0]          s_err_i,
  output logic [DATA_W-1:0]      s_dat_o,
  output logic [ADDR_W-1:0]      s_adr_o,
  output logic [2:0]             s_cti_o,
  output logic [DATA_W/8-1:0]    s_sel_o,
  output logic                   s_we_o,
  output logic                   s_cyc_o,
  output logic [NS-1:0]          s_stb_o,
  output logic [NM-1:0]          gnt_o,
  output logic                   tmo_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam int MPW   = (NM > 1) ? $clog2(NM) : 1;
  localparam int SPW   = (NS > 1) ? $clog2(NS) : 1;
  localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WD_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t          state_q, state_d;
  logic [NM-1:0]   gnt_q, gnt_d;
  logic [MPW-1:0]  rr_q, rr_d;
  logic [MPW-1:0]  own_q, own_d;
  logic [CW-1:0]   wd_q, wd_d;
  logic            um_q, um_d;

  logic            bus_cyc, bus_stb;
  logic            hit, sel_v, unmapped;
  logic [SPW-1:0]  sidx;
  logic            s_ack, s_err, tmo;
  logic            int_err, resp_ack, resp_err;
  logic            found;
  int              idx;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= MPW'(NM - 1);
      own_q   <= '0;
      wd_q    <= '0;
      um_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      own_q   <= own_d;
      wd_q    <= wd_d;
      um_q    <= um_d;
    end
  end

  // Search starts one past the last owner so every requester gets a turn.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    own_d   = own_q;
    found   = 1'b0;
    idx     = 0;
    case (state_q)
      IDLE: begin
        if (|m_cyc_i) begin
          for (int i = 1; i <= NM; i++) begin
            idx = (int'(rr_q) + i) % NM;
            if (!found && m_cyc_i[idx]) begin
              found = 1'b1;
              own_d = MPW'(idx);
            end
          end
          gnt_d        = '0;
          gnt_d[own_d] = 1'b1;
          state_d      = OWNED;
        end
      end
      OWNED: begin
        if (!m_cyc_i[own_q]) begin
          rr_d    = own_q;
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_dat_o = '0;
    s_adr_o = '0;
    s_cti_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    bus_cyc = 1'b0;
    bus_stb = 1'b0;
    for (int k = 0; k < NM; k++) begin
      if (gnt_q[k]) begin
        s_dat_o = s_dat_o | m_dat_i[k*DATA_W +: DATA_W];
        s_adr_o = s_adr_o | m_adr_i[k*ADDR_W +: ADDR_W];
        s_cti_o = s_cti_o | m_cti_i[k*3 +: 3];
        s_sel_o = s_sel_o | m_sel_i[k*SEL_W +: SEL_W];
        s_we_o  = s_we_o  | m_we_i[k];
        bus_cyc = bus_cyc | m_cyc_i[k];
        bus_stb = bus_stb | m_stb_i[k];
      end
    end
  end

  // Descending scan so the lowest matching slave index wins.
  always_comb begin
    hit  = 1'b0;
    sidx = '0;
    for (int k = NS - 1; k >= 0; k--) begin
      if (s_adr_o[ADDR_W-1 -: S_ADDR_W] ==
          S_ADDR_MAP[k*S_ADDR_W +: S_ADDR_W]) begin
        hit  = 1'b1;
        sidx = SPW'(k);
      end
    end
  end

  assign s_cyc_o  = bus_cyc;
  assign sel_v    = bus_cyc & bus_stb & hit;
  assign unmapped = bus_cyc & bus_stb & ~hit;

  always_comb begin
    s_stb_o = '0;
    if (sel_v) s_stb_o[sidx] = 1'b1;
  end

  assign s_ack   = sel_v & s_ack_i[sidx];
  assign s_err   = sel_v & s_err_i[sidx];
  assign m_dat_o = sel_v ? s_dat_i[sidx*DATA_W +: DATA_W] : '0;

  // Expiry is suppressed when the slave answers in the same cycle.
  assign tmo = (TIMEOUT != 0) && sel_v && !s_ack && !s_err &&
               (wd_q == WD_LAST);

  always_comb begin
    wd_d = wd_q + 1'b1;
    if (TIMEOUT == 0 || !sel_v || s_ack || s_err || tmo ||
        gnt_d != gnt_q)
      wd_d = '0;
  end

  assign um_d = unmapped & ~um_q & (gnt_d == gnt_q);

  assign int_err  = um_q | tmo;
  assign resp_ack = s_ack;
  assign resp_err = ~s_ack & (s_err | int_err);

  assign m_ack_o = gnt_q & {NM{resp_ack}};
  assign m_err_o = gnt_q & {NM{resp_err}};
  assign gnt_o   = gnt_q;
  assign tmo_o   = tmo;

endmodule
